// File: rtl/scene_compositor.sv
// Scene compositor: double-buffered object positions and a 2-stage pixel hit/priority pipeline.
// Optional build macro SMASH_FLASH_EN adds the smash-ball flash (obj_id 5).

module scene_obj_hit #(
    parameter int W = 128
) (
    input  logic [9:0] h_cnt,
    input  logic [9:0] v_cnt,
    input  logic [9:0] pos_x,
    input  logic [9:0] pos_y,
    output logic       hit,
    output logic [6:0] dx,
    output logic [6:0] dy
);
    logic [10:0] dx_full, dy_full;

    // Subtract-and-compare keeps the test exact when pos + W would wrap past 1023.
    always_comb begin
        dx_full = {1'b0, h_cnt} - {1'b0, pos_x};
        dy_full = {1'b0, v_cnt} - {1'b0, pos_y};
        hit     = (h_cnt >= pos_x) && (v_cnt >= pos_y) &&
                  (dx_full < 11'(W)) && (dy_full < 11'(W));
        dx      = dx_full[6:0];
        dy      = dy_full[6:0];
    end
endmodule

module scene_compositor #(
    parameter int P_W     = 128,
    parameter int BALL_W  = 80,
    parameter int NET_X0  = 317,
    parameter int NET_X1  = 323,
    parameter int NET_TOP = 300
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid,
    input  logic [9:0]  p1_pos_x,
    input  logic [9:0]  p1_pos_y,
    input  logic [9:0]  p2_pos_x,
    input  logic [9:0]  p2_pos_y,
    input  logic [9:0]  ball_pos_x,
    input  logic [9:0]  ball_pos_y,
    input  logic        ball_is_smash,
    input  logic        frame_start,
    input  logic [9:0]  h_cnt,
    input  logic [9:0]  v_cnt,
    input  logic        pix_en,
    output logic [2:0]  obj_id,
    output logic [13:0] sprite_addr,
    output logic        obj_valid,
    output logic        pending,
    output logic [7:0]  drop_cnt
);
    localparam int NUM_OBJ  = 3;
    localparam int OBJ_P1   = 0;
    localparam int OBJ_P2   = 1;
    localparam int OBJ_BALL = 2;
    localparam int STAGES   = 2;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
    } pos_t;

    // loaded marks a set that has been committed at least once; the zeroed
    // post-reset set must not paint sprites at (0,0).
    typedef struct packed {
        pos_t [NUM_OBJ-1:0] pos;
        logic               smash;
        logic               loaded;
    } obj_set_t;

    obj_set_t shadow, active, cap;

    always_comb begin
        cap                = '0;
        cap.pos[OBJ_P1]    = {p1_pos_x, p1_pos_y};
        cap.pos[OBJ_P2]    = {p2_pos_x, p2_pos_y};
        cap.pos[OBJ_BALL]  = {ball_pos_x, ball_pos_y};
        cap.smash          = ball_is_smash;
        cap.loaded         = 1'b1;
    end

    // Commit uses the pre-edge shadow, so a same-cycle strobe lands in shadow for the next frame.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow   <= '0;
            active   <= '0;
            pending  <= 1'b0;
            drop_cnt <= '0;
        end else begin
            if (frame_start && pending)
                active <= shadow;
            if (valid) begin
                shadow  <= cap;
                pending <= 1'b1;
                if (pending && !frame_start && drop_cnt != 8'hFF)
                    drop_cnt <= drop_cnt + 8'd1;
            end else if (frame_start) begin
                pending <= 1'b0;
            end
        end
    end

    // Stage 1: per-object hit test against the active set
    logic [NUM_OBJ-1:0]        hit_c, hit_s1;
    logic [NUM_OBJ-1:0][6:0]   dx_c, dy_c, dx_s1, dy_s1;
    logic                      net_c, net_s1;
    logic [STAGES:1]           vld_q;
    logic [STAGES:0]           vld_pipe;

    assign vld_pipe = {vld_q, pix_en};

    for (genvar g = 0; g < NUM_OBJ; g++) begin : g_obj
        scene_obj_hit #(
            .W (g == OBJ_BALL ? BALL_W : P_W)
        ) u_hit (
            .h_cnt (h_cnt),
            .v_cnt (v_cnt),
            .pos_x (active.pos[g].x),
            .pos_y (active.pos[g].y),
            .hit   (hit_c[g]),
            .dx    (dx_c[g]),
            .dy    (dy_c[g])
        );
    end

    assign net_c = (h_cnt >= 10'(NET_X0)) && (h_cnt < 10'(NET_X1)) &&
                   (v_cnt >= 10'(NET_TOP));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hit_s1 <= '0;
            dx_s1  <= '0;
            dy_s1  <= '0;
            net_s1 <= 1'b0;
            vld_q  <= '0;
        end else begin
            hit_s1 <= hit_c & {NUM_OBJ{active.loaded}};
            dx_s1  <= dx_c;
            dy_s1  <= dy_c;
            net_s1 <= net_c;
            vld_q  <= vld_pipe[STAGES-1:0];
        end
    end

    // Stage 2: priority resolve and ROM address
    logic        flash_on;
    logic [2:0]  id_nxt;
    logic [13:0] addr_nxt, ball_addr;

`ifdef SMASH_FLASH_EN
    logic [2:0] flash_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n)
            flash_cnt <= '0;
        else if (frame_start)
            flash_cnt <= flash_cnt + 3'd1;
    end

    assign flash_on = active.smash & flash_cnt[2];
`else
    logic unused_smash;
    assign unused_smash = active.smash ^ shadow.smash;
    assign flash_on     = 1'b0;
`endif

    // dy*80 + dx as shifts; both coordinates are below 80 so it peaks at 6399.
    assign ball_addr = ({7'd0, dy_s1[OBJ_BALL]} << 6) + ({7'd0, dy_s1[OBJ_BALL]} << 4) +
                       {7'd0, dx_s1[OBJ_BALL]};

    always_comb begin
        id_nxt   = 3'd0;
        addr_nxt = '0;
        if (vld_pipe[1]) begin
            if (hit_s1[OBJ_BALL]) begin
                id_nxt   = flash_on ? 3'd5 : 3'd4;
                addr_nxt = ball_addr;
            end else if (hit_s1[OBJ_P1]) begin
                id_nxt   = 3'd2;
                addr_nxt = {dy_s1[OBJ_P1], dx_s1[OBJ_P1]};
            end else if (hit_s1[OBJ_P2]) begin
                id_nxt   = 3'd3;
                addr_nxt = {dy_s1[OBJ_P2], 7'd127 - dx_s1[OBJ_P2]};
            end else if (net_s1) begin
                id_nxt   = 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            obj_id      <= '0;
            sprite_addr <= '0;
        end else begin
            obj_id      <= id_nxt;
            sprite_addr <= addr_nxt;
        end
    end

    assign obj_valid = vld_pipe[STAGES];
endmodule
